// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//  Shared definitions for the alu command sequencer and the alu itself.
//  Holds the default widths, the op code values the alu understands, and the
//  sequencer FSM state encodings.
//  No ports; import with alu_pkg::*.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 64;
  localparam int FIFO_D = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;

  // Sequencer FSM encodings, also visible on the debug state output.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // True for the op codes the alu actually implements.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
//  Command and result ports of the alu sequencer bundled into one interface.
//  Handshake rule for both channels: a beat transfers on a rising clock edge
//  where valid and ready are both 1. A producer holding valid keeps its payload
//  stable until that edge; ready may depend on nothing the producer drives in
//  the same cycle, so there is no combinational loop through the handshake.
//  Signals:
//    cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b   upstream command channel
//    res_valid/res_ready/res_data/res_err     downstream result channel
//  Modports:
//    master  the side that issues commands and consumes results
//    slave   the sequencer
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int OP_W  = 3,
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [IN_W-1:0]  cmd_a;
  logic [IN_W-1:0]  cmd_b;

  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//  Combinational arithmetic block driven by alu_seq.
//  Operands are signed and sign-extended to the result width before the
//  operation, so ADD never overflows and MUL yields the full signed product.
//  Unknown op codes produce 0.
//  Ports:
//    op_code  in   OP_W   operation select
//    alu_in1  in   IN_W   signed operand 1
//    alu_in2  in   IN_W   signed operand 2
//    alu_out  out  OUT_W  result
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int P_OP_W  = OP_W,
  parameter int P_IN_W  = IN_W,
  parameter int P_OUT_W = OUT_W
) (
  input  logic [P_OP_W-1:0]  op_code,
  input  logic [P_IN_W-1:0]  alu_in1,
  input  logic [P_IN_W-1:0]  alu_in2,
  output logic [P_OUT_W-1:0] alu_out
);

  logic signed [P_OUT_W-1:0] w_a;
  logic signed [P_OUT_W-1:0] w_b;

  assign w_a = {{(P_OUT_W-P_IN_W){alu_in1[P_IN_W-1]}}, alu_in1};
  assign w_b = {{(P_OUT_W-P_IN_W){alu_in2[P_IN_W-1]}}, alu_in2};

  always_comb begin
    alu_out = '0;
    if (op_code == P_OP_W'(OP_ADD)) begin
      alu_out = w_a + w_b;
    end else if (op_code == P_OP_W'(OP_MUL)) begin
      // Truncated product of sign-extended operands equals the signed product.
      alu_out = w_a * w_b;
    end
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
//  Synchronous FIFO holding packed {op, a, b} commands for alu_seq.
//  Full/empty come from an occupancy counter; pointers wrap naturally.
//  A push while full or a pop while empty is ignored.
//  Ports:
//    clk, rst  clock, asynchronous active-high reset
//    i_push    write i_din when not full
//    i_din     entry to write
//    i_pop     advance read pointer when not empty
//    o_dout    current head entry (valid when !o_empty)
//    o_full    FIFO holds D entries
//    o_empty   FIFO holds no entries
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int W = 67,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(D));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//  Command-side driver for the combinational alu. Commands arriving on the
//  command channel are buffered in a small FIFO and issued one at a time to
//  the alu through registered op/operand outputs. One cycle later the alu
//  result is captured and offered on the result channel, in command order.
//  Ports:
//    clk, rst     clock, asynchronous active-high reset
//    bus          alu_seq_if slave modport (command and result channels)
//    alu_op_code  registered op code to the alu
//    alu_in1      registered operand 1 to the alu
//    alu_in2      registered operand 2 to the alu
//    alu_out      combinational alu result
//    o_state      current FSM state (IDLE/DRIVE/HOLD encodings from alu_pkg)
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int P_IN_W   = IN_W,
  parameter int P_OUT_W  = OUT_W,
  parameter int P_OP_W   = OP_W,
  parameter int P_FIFO_D = FIFO_D
) (
  input  logic               clk,
  input  logic               rst,
  alu_seq_if.slave           bus,
  output logic [P_OP_W-1:0]  alu_op_code,
  output logic [P_IN_W-1:0]  alu_in1,
  output logic [P_IN_W-1:0]  alu_in2,
  input  logic [P_OUT_W-1:0] alu_out,
  output logic [1:0]         o_state
);

  localparam int CMD_W = P_OP_W + 2 * P_IN_W;

  logic [1:0]         r_state;
  logic [P_OP_W-1:0]  r_alu_op;
  logic [P_IN_W-1:0]  r_alu_a;
  logic [P_IN_W-1:0]  r_alu_b;
  logic [P_OUT_W-1:0] r_res_data;
  logic               r_res_err;
  logic               r_res_valid;

  logic [CMD_W-1:0]   w_head;
  logic [P_OP_W-1:0]  w_head_op;
  logic [P_IN_W-1:0]  w_head_a;
  logic [P_IN_W-1:0]  w_head_b;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_res_fire;

  // cmd_ready depends only on the registered count, so a pop in the same
  // cycle never opens a slot for a full FIFO.
  assign bus.cmd_ready = !w_full;
  assign w_push        = bus.cmd_valid && !w_full;

  assign w_res_fire = (r_state == ST_HOLD) && bus.res_ready;
  // Pop whenever the FSM is about to issue: from IDLE, or out of HOLD on the
  // result transfer so the next command goes straight to DRIVE.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_res_fire);

  assign w_head_op = w_head[2*P_IN_W +: P_OP_W];
  assign w_head_a  = w_head[P_IN_W +: P_IN_W];
  assign w_head_b  = w_head[0 +: P_IN_W];

  alu_cmd_fifo #(
    .W (CMD_W),
    .D (P_FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_op <= w_head_op;
            r_alu_a  <= w_head_a;
            r_alu_b  <= w_head_b;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // The alu has had one full cycle to settle on the registered inputs.
          r_res_data  <= alu_out;
          r_res_err   <= !op_is_legal(OP_W'(r_alu_op));
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_res_fire) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_alu_op <= w_head_op;
              r_alu_a  <= w_head_a;
              r_alu_b  <= w_head_b;
              r_state  <= ST_DRIVE;
            end else begin
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_op_code   = r_alu_op;
  assign alu_in1       = r_alu_a;
  assign alu_in2       = r_alu_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//  Directed bench for alu_seq wired to the real alu. Inputs change and outputs
//  are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.OP_W(OP_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus_if ();

  logic [OP_W-1:0]  alu_op_code;
  logic [IN_W-1:0]  alu_in1;
  logic [IN_W-1:0]  alu_in2;
  logic [OUT_W-1:0] alu_out;
  logic [1:0]       dbg_state;

  alu_seq #(
    .P_IN_W(IN_W), .P_OUT_W(OUT_W), .P_OP_W(OP_W), .P_FIFO_D(FIFO_D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .alu_op_code (alu_op_code),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .o_state     (dbg_state)
  );

  alu u_alu (
    .op_code (alu_op_code),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out)
  );

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command until accepted (bounded); returns after the accept edge.
  task automatic push_cmd(input logic [OP_W-1:0] op, input logic [IN_W-1:0] a,
                          input logic [IN_W-1:0] b, output bit ok);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.cmd_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    bus_if.cmd_valid = 1'b0;
  endtask

  // Counts edges until res_valid is seen (bounded).
  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!bus_if.res_valid && cyc < 60) begin
      step();
      cyc++;
    end
    ok = bus_if.res_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok;
    total++;
    if (bus_if.res_valid !== 1'b0 || bus_if.res_data !== '0 || bus_if.res_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_res: valid=%b data=%h err=%b required 0/0/0",
               bus_if.res_valid, bus_if.res_data, bus_if.res_err);
    end
    total++;
    if (alu_op_code !== '0 || alu_in1 !== '0 || alu_in2 !== '0) begin
      bad++;
      $display("FAIL reset_alu: op=%h in1=%h in2=%h required 0", alu_op_code, alu_in1, alu_in2);
    end
    total++;
    if (bus_if.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_ready: cmd_ready=%b state=%0d required 1/IDLE", bus_if.cmd_ready, dbg_state);
    end
    // Reset mid-operation: command sitting in DRIVE.
    bus_if.res_ready = 1'b1;
    push_cmd(OP_MUL, 32'd3, 32'd5, ok);
    step();
    total++;
    if (!ok || alu_in1 !== 32'd3 || dbg_state !== ST_DRIVE) begin
      bad++;
      $display("FAIL reset_pre_drive: ok=%b in1=%h state=%0d required 1/3/DRIVE", ok, alu_in1, dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (alu_in1 !== '0 || alu_op_code !== '0 || bus_if.res_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_async: in1=%h op=%h valid=%b state=%0d required 0", alu_in1, alu_op_code,
               bus_if.res_valid, dbg_state);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%b res_valid=%b required 1/0", bus_if.cmd_ready, bus_if.res_valid);
    end
  endtask

  task automatic test_add();
    bit ok, vok;
    int cyc;
    bus_if.res_ready = 1'b1;
    push_cmd(OP_ADD, -32'sd5, 32'sd7, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || cyc != 2) begin
      bad++;
      $display("FAIL add_latency: accepted=%b valid=%b edges=%0d required 2", ok, vok, cyc);
    end
    total++;
    if (bus_if.res_data !== 64'd2 || bus_if.res_err !== 1'b0) begin
      bad++;
      $display("FAIL add_neg: data=%h err=%b required %h/0", bus_if.res_data, bus_if.res_err, 64'd2);
    end
    step();
    push_cmd(OP_ADD, 32'h7FFF_FFFF, 32'd1, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || bus_if.res_data !== 64'h0000_0000_8000_0000 || bus_if.res_err !== 1'b0) begin
      bad++;
      $display("FAIL add_max: data=%h err=%b required 0000000080000000/0", bus_if.res_data, bus_if.res_err);
    end
    step();
  endtask

  task automatic test_mul();
    bit ok, vok;
    int cyc;
    bus_if.res_ready = 1'b1;
    push_cmd(OP_MUL, -32'sd3, 32'sd4, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || bus_if.res_data !== 64'hFFFF_FFFF_FFFF_FFF4 || bus_if.res_err !== 1'b0) begin
      bad++;
      $display("FAIL mul_neg: data=%h err=%b required fffffffffffffff4/0", bus_if.res_data, bus_if.res_err);
    end
    step();
    push_cmd(OP_MUL, 32'h7FFF_FFFF, 32'd2, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || bus_if.res_data !== 64'h0000_0000_FFFF_FFFE) begin
      bad++;
      $display("FAIL mul_max: data=%h required 00000000fffffffe", bus_if.res_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted;
    int got_n;
    int waited;
    bit sixth_in;
    bit do_xfer, do_acc;
    logic [OUT_W-1:0] d, e;
    bus_if.res_ready = 1'b0;
    accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = OP_ADD;
      bus_if.cmd_a     = IN_W'(i);
      bus_if.cmd_b     = '0;
      if (!bus_if.cmd_ready) break;
      step();
      accepted++;
      exp_q.push_back(OUT_W'(i));
    end
    // The sixth command is still offered; it must stay blocked.
    repeat (3) step();
    total++;
    if (accepted != 5 || bus_if.cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: accepted=%0d cmd_ready=%b required 5/0", accepted, bus_if.cmd_ready);
    end
    bus_if.res_ready = 1'b1;
    sixth_in = (accepted != 5);
    got_n = 0;
    waited = 0;
    while (got_n < 6 && waited < 80) begin
      do_xfer = bus_if.res_valid;
      do_acc  = bus_if.cmd_valid && bus_if.cmd_ready;
      d       = bus_if.res_data;
      step();
      waited++;
      if (do_acc) begin
        exp_q.push_back(OUT_W'(6));
        bus_if.cmd_valid = 1'b0;
        sixth_in = 1'b1;
      end
      if (do_xfer) begin
        got_n++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL bp_order: result %0d data=%h required %h", got_n, d, e);
        end
      end
    end
    bus_if.cmd_valid = 1'b0;
    total++;
    if (got_n != 6 || !sixth_in) begin
      bad++;
      $display("FAIL bp_count: results=%0d sixth_accepted=%b required 6/1", got_n, sixth_in);
    end
    exp_q.delete();
  endtask

  task automatic test_illegal();
    bit ok, vok;
    int cyc;
    bus_if.res_ready = 1'b1;
    push_cmd(3'b101, 32'd9, 32'd9, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || bus_if.res_data !== '0 || bus_if.res_err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_op: data=%h err=%b required 0/1", bus_if.res_data, bus_if.res_err);
    end
    step();
    push_cmd(OP_ADD, 32'd1, 32'd1, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || bus_if.res_data !== 64'd2 || bus_if.res_err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_next: data=%h err=%b required 2/0", bus_if.res_data, bus_if.res_err);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int t_x[3];
    int n, cyc;
    logic [OUT_W-1:0] d, e;
    bus_if.res_ready = 1'b1;
    exp_q.push_back(64'd6);
    exp_q.push_back(64'd20);
    exp_q.push_back(64'd42);
    push_cmd(OP_MUL, 32'd2, 32'd3, ok1);
    push_cmd(OP_MUL, 32'd4, 32'd5, ok2);
    push_cmd(OP_MUL, 32'd6, 32'd7, ok3);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 40) begin
      if (bus_if.res_valid) begin
        d = bus_if.res_data;
        e = exp_q.pop_front();
        t_x[n] = cyc;
        n++;
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL b2b_data: result %0d data=%h required %h", n, d, e);
        end
      end
      step();
      cyc++;
    end
    total++;
    if (!(ok1 && ok2 && ok3) || n != 3 || (t_x[1] - t_x[0]) != 2 || (t_x[2] - t_x[1]) != 2) begin
      bad++;
      $display("FAIL b2b_rate: results=%0d gaps=%0d,%0d required 3 results gap 2",
               n, t_x[1] - t_x[0], t_x[2] - t_x[1]);
    end
    // alu inputs keep the last issued command once idle.
    repeat (2) step();
    total++;
    if (alu_op_code !== OP_MUL || alu_in1 !== 32'd6 || alu_in2 !== 32'd7) begin
      bad++;
      $display("FAIL alu_hold: op=%h in1=%h in2=%h required 1/6/7", alu_op_code, alu_in1, alu_in2);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_hold();
    bit ok, vok;
    int cyc, stray;
    bus_if.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(OP_ADD, 32'd50 + 32'(i), 32'd0, ok);
    end
    wait_valid(cyc, vok);
    total++;
    if (!vok || dbg_state !== ST_HOLD) begin
      bad++;
      $display("FAIL rh_hold: valid=%b state=%0d required 1/HOLD", vok, dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus_if.res_valid !== 1'b0 || bus_if.res_data !== '0 || alu_in1 !== '0 || bus_if.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rh_clear: valid=%b data=%h in1=%h cmd_ready=%b required 0/0/0/1",
               bus_if.res_valid, bus_if.res_data, alu_in1, bus_if.cmd_ready);
    end
    step();
    rst = 1'b0;
    bus_if.res_ready = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus_if.res_valid) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL rh_no_results: stray valid cycles=%0d required 0", stray);
    end
    push_cmd(OP_ADD, 32'd10, 32'd20, ok);
    wait_valid(cyc, vok);
    total++;
    if (!ok || !vok || cyc != 2 || bus_if.res_data !== 64'd30) begin
      bad++;
      $display("FAIL rh_after: edges=%0d data=%h required 2/%h", cyc, bus_if.res_data, 64'd30);
    end
    step();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst              = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_hold();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
